window_accumulator: RTL
=======================

WINDOW_ACCUMULATOR -- requirements
Module: window_accumulator

Interface
REQ-001 SHALL have parameter DATA_W, default 18, meaning signed ADC sample width.
REQ-002 SHALL have parameter SUM_W, default 48, meaning signed accumulator width.
REQ-003 SHALL have parameter CNT_W, default 32, meaning width of the sample and drop counters.
REQ-004 SHALL have port clk, input, 1, the single clock; all logic runs on its rising edge.
REQ-005 SHALL have port rst, input, 1, the reset; it is asynchronous and active-high.
REQ-006 SHALL have port in_data, input, DATA_W, signed sample, aligned with the win_* inputs.
REQ-007 SHALL have ports win_valid, win_first and win_last, inputs, 1 each, the window strobes from the upstream suppressor stage.
REQ-008 SHALL have port out_valid, output, 1, meaning a result is held.
REQ-009 SHALL have port out_ready, input, 1, meaning the consumer accepts the held result.
REQ-010 SHALL have port out_sum, output, SUM_W, the signed window sum.
REQ-011 SHALL have port out_count, output, CNT_W, the number of samples summed.
REQ-012 SHALL have port out_sat, output, 1, meaning the sum saturated in this window.
REQ-013 SHALL have port drop_cnt, output, CNT_W, the count of results lost to backpressure.
REQ-014 SHALL have port busy, output, 1, meaning the state is ACCUM.

Function
REQ-015 SHALL implement two states, IDLE and ACCUM.
REQ-016 SHALL, when win_first=1 in either state, clear the running sum and count, then add in_data if win_valid=1, then enter ACCUM; any partial window is discarded and produces no result.
REQ-017 SHALL, in ACCUM with win_valid=1 and win_first=0, add the sign-extended in_data to the sum and increment the count by 1.
REQ-018 SHALL ignore win_valid and win_last in IDLE when win_first=0.
REQ-019 SHALL, when win_last=1 and the window is accumulating (ACCUM, or win_first in the same cycle), include that cycle's sample if win_valid=1, load the result register on the next edge and return to IDLE.
REQ-020 SHALL treat win_first=win_last=1 in the same cycle as a complete one-cycle window.
REQ-021 SHALL assert out_valid exactly 1 cycle after the win_last cycle; out_sum, out_count and out_sat SHALL be stable while out_valid=1 and out_ready=0.
REQ-022 SHALL complete a transfer on a cycle where out_valid=1 and out_ready=1, then deassert out_valid unless a new result loads in the same cycle.
REQ-023 SHALL keep the held result when a new result arrives while out_valid=1 and out_ready=0; the new result is discarded and drop_cnt increments.
REQ-024 SHALL load a new result arriving in the same cycle as a completed transfer, keep out_valid=1, and not increment drop_cnt.
REQ-025 SHALL saturate the sum at the signed SUM_W limits; once saturated it stays at the limit for the rest of the window and out_sat=1.
REQ-026 SHALL saturate out_count at all-ones and drop_cnt at all-ones.
REQ-027 SHALL allow a window with zero valid samples, giving out_sum=0 and out_count=0.

Reset
REQ-028 SHALL, while rst=1, force state=IDLE and out_valid, out_sum, out_count, out_sat, drop_cnt, busy, the running sum and the running count to 0.
REQ-029 SHALL discard a window in progress when rst asserts mid-window, and produce no result after rst deasserts.
REQ-030 SHALL not start a window on the first edge after rst deasserts unless win_first=1 on that edge.

Configuration
REQ-031 SHALL, with WINDOW_ACC_MINMAX_EN defined, add outputs out_min and out_max (DATA_W each), holding the min and max valid sample of the window and following the same hold rules as out_sum.
REQ-032 SHALL give out_min=0 and out_max=0 for a window with zero valid samples.
REQ-033 SHALL, without WINDOW_ACC_MINMAX_EN, have no out_min or out_max ports and no min/max logic.

Structure
REQ-034 SHALL take the state enum (IDLE, ACCUM), the result struct (sum, count, sat and optional min/max) and the saturation limit constants from the shared package window_acc_pkg.
REQ-035 SHALL place the output register with valid/ready hold and drop counting in one sub-module, result_hold_reg; the accumulate datapath SHALL be in the top level.

Verification
REQ-036 SHALL cover: first on cycle 0, valid on cycles 2-5 with data 1,2,3,4, last on cycle 5, out_ready=1 -> out_valid on cycle 6, out_sum=10, out_count=4, out_sat=0.
REQ-037 SHALL cover: first=last=1 with valid=1 and data=-7 -> next cycle out_sum=-7, out_count=1.
REQ-038 SHALL cover: out_ready=0 and two windows completing -> first result held unchanged, drop_cnt=1; then out_ready=1 -> transfer, out_valid=0.
REQ-039 SHALL cover: SUM_W=20 with 16 samples of +131071 -> out_sum=524287, out_sat=1.
REQ-040 SHALL cover: win_first again mid-window after 3 samples -> no result for the partial window; the next result contains only the new window's samples.
REQ-041 SHALL cover: rst pulse mid-window -> all outputs 0, no out_valid, drop_cnt=0; with WINDOW_ACC_MINMAX_EN, data 5,-3,9 -> out_min=-3, out_max=9.

Source files
------------

// File: rtl/window_acc_pkg.sv
// window_acc_pkg: shared state enum, result struct (min/max fields under WINDOW_ACC_MINMAX_EN) and saturation limits
package window_acc_pkg;
   localparam int MAX_DATA_W = 32;
   localparam int MAX_SUM_W = 64;
   localparam int MAX_CNT_W = 64;
   typedef enum logic {IDLE = 1'b0, ACCUM = 1'b1} state_e;
   typedef struct packed {
      logic signed [MAX_SUM_W-1:0] sum;
      logic [MAX_CNT_W-1:0] count;
      logic sat;
`ifdef WINDOW_ACC_MINMAX_EN
      logic signed [MAX_DATA_W-1:0] lo;
      logic signed [MAX_DATA_W-1:0] hi;
`endif
   } result_t;
   function automatic logic signed [MAX_SUM_W-1:0] sum_hi(int w);
      return (MAX_SUM_W'(1) << (w - 1)) - MAX_SUM_W'(1);
   endfunction
   function automatic logic signed [MAX_SUM_W-1:0] sum_lo(int w);
      return ~sum_hi(w);
   endfunction
endpackage

// File: rtl/window_acc_if.sv
// window_acc_if: window strobes in, held result and status out; out_min/out_max only with WINDOW_ACC_MINMAX_EN
interface window_acc_if #(
   parameter int DATA_W = 18,
   parameter int SUM_W = 48,
   parameter int CNT_W = 32
);
   logic signed [DATA_W-1:0] in_data;
   logic win_valid;
   logic win_first;
   logic win_last;
   logic out_valid;
   logic out_ready;
   logic signed [SUM_W-1:0] out_sum;
   logic [CNT_W-1:0] out_count;
   logic out_sat;
   logic [CNT_W-1:0] drop_cnt;
   logic busy;
`ifdef WINDOW_ACC_MINMAX_EN
   logic signed [DATA_W-1:0] out_min;
   logic signed [DATA_W-1:0] out_max;
   modport master (
      output in_data, win_valid, win_first, win_last, out_ready,
      input out_valid, out_sum, out_count, out_sat, drop_cnt, busy, out_min, out_max
   );
   modport slave (
      input in_data, win_valid, win_first, win_last, out_ready,
      output out_valid, out_sum, out_count, out_sat, drop_cnt, busy, out_min, out_max
   );
`else
   modport master (
      output in_data, win_valid, win_first, win_last, out_ready,
      input out_valid, out_sum, out_count, out_sat, drop_cnt, busy
   );
   modport slave (
      input in_data, win_valid, win_first, win_last, out_ready,
      output out_valid, out_sum, out_count, out_sat, drop_cnt, busy
   );
`endif
endinterface

// File: rtl/result_hold_reg.sv
// result_hold_reg: one-deep result register with valid/ready hold and saturating drop counter
module result_hold_reg
   import window_acc_pkg::*;
#(
   parameter int CNT_W = 32
) (
   input logic clk,
   input logic rst,
   input logic load_i,
   input result_t res_i,
   input logic ready_i,
   output logic valid_o,
   output result_t res_o,
   output logic [CNT_W-1:0] drop_o
);
   logic valid_q, valid_d, take;
   result_t res_q, res_d;
   logic [CNT_W-1:0] drop_q, drop_d;
   always_comb begin
      take = load_i && (!valid_q || ready_i);
      valid_d = take || (valid_q && !ready_i);
      res_d = take ? res_i : res_q;
      drop_d = load_i && !take && !(&drop_q) ? drop_q + CNT_W'(1) : drop_q;
   end
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         valid_q <= 1'b0;
         res_q <= '0;
         drop_q <= '0;
      end else begin
         valid_q <= valid_d;
         res_q <= res_d;
         drop_q <= drop_d;
      end
   assign valid_o = valid_q;
   assign res_o = res_q;
   assign drop_o = drop_q;
endmodule

// File: rtl/window_accumulator.sv
// window_accumulator: windowed signed sum/count with saturation; WINDOW_ACC_MINMAX_EN adds window min/max
module window_accumulator
   import window_acc_pkg::*;
#(
   parameter int DATA_W = 18,
   parameter int SUM_W = 48,
   parameter int CNT_W = 32
) (
   input logic clk,
   input logic rst,
   window_acc_if.slave bus
);
   localparam logic signed [SUM_W-1:0] SUM_MAX = SUM_W'(sum_hi(SUM_W));
   localparam logic signed [SUM_W-1:0] SUM_MIN = SUM_W'(sum_lo(SUM_W));
   state_e state_q, state_d;
   logic accum, add, done, keep;
   logic signed [SUM_W-1:0] sum_q, sum_d, sum_base, sum_nxt;
   logic signed [SUM_W:0] sum_ext;
   logic [CNT_W-1:0] cnt_q, cnt_d, cnt_base, cnt_nxt;
   logic sat_q, sat_d, sat_base, sat_nxt, ovf;
   result_t res_d, res_held;
`ifdef WINDOW_ACC_MINMAX_EN
   logic signed [DATA_W-1:0] lo_q, lo_d, lo_base, lo_nxt;
   logic signed [DATA_W-1:0] hi_q, hi_d, hi_base, hi_nxt;
`endif
   always_ff @(posedge clk or posedge rst)
      if (rst) state_q <= IDLE;
      else state_q <= state_d;
   always_comb state_d = accum && !bus.win_last ? ACCUM : IDLE;
   always_comb begin
      accum = bus.win_first || state_q == ACCUM;
      add = accum && bus.win_valid;
      done = accum && bus.win_last;
      keep = accum && !bus.win_last;
      bus.busy = state_q == ACCUM;
   end
   // a saturated sum sticks at its limit until the window ends
   always_comb begin
      sum_base = bus.win_first ? '0 : sum_q;
      cnt_base = bus.win_first ? '0 : cnt_q;
      sat_base = bus.win_first ? 1'b0 : sat_q;
      sum_ext = {sum_base[SUM_W-1], sum_base} + (SUM_W+1)'(bus.in_data);
      ovf = add && !sat_base && sum_ext[SUM_W] != sum_ext[SUM_W-1];
      sum_nxt = !add || sat_base ? sum_base : ovf ? (sum_ext[SUM_W] ? SUM_MIN : SUM_MAX) : sum_ext[SUM_W-1:0];
      sat_nxt = sat_base || ovf;
      cnt_nxt = add && !(&cnt_base) ? cnt_base + CNT_W'(1) : cnt_base;
      sum_d = keep ? sum_nxt : '0;
      cnt_d = keep ? cnt_nxt : '0;
      sat_d = keep && sat_nxt;
      res_d.sum = MAX_SUM_W'(sum_nxt);
      res_d.count = MAX_CNT_W'(cnt_nxt);
      res_d.sat = sat_nxt;
`ifdef WINDOW_ACC_MINMAX_EN
      lo_base = bus.win_first ? '0 : lo_q;
      hi_base = bus.win_first ? '0 : hi_q;
      lo_nxt = add && (cnt_base == '0 || bus.in_data < lo_base) ? bus.in_data : lo_base;
      hi_nxt = add && (cnt_base == '0 || bus.in_data > hi_base) ? bus.in_data : hi_base;
      lo_d = keep ? lo_nxt : '0;
      hi_d = keep ? hi_nxt : '0;
      res_d.lo = MAX_DATA_W'(lo_nxt);
      res_d.hi = MAX_DATA_W'(hi_nxt);
`endif
   end
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         sum_q <= '0;
         cnt_q <= '0;
         sat_q <= 1'b0;
`ifdef WINDOW_ACC_MINMAX_EN
         lo_q <= '0;
         hi_q <= '0;
`endif
      end else begin
         sum_q <= sum_d;
         cnt_q <= cnt_d;
         sat_q <= sat_d;
`ifdef WINDOW_ACC_MINMAX_EN
         lo_q <= lo_d;
         hi_q <= hi_d;
`endif
      end
   result_hold_reg #(.CNT_W(CNT_W)) u_hold (
      .clk(clk),
      .rst(rst),
      .load_i(done),
      .res_i(res_d),
      .ready_i(bus.out_ready),
      .valid_o(bus.out_valid),
      .res_o(res_held),
      .drop_o(bus.drop_cnt)
   );
   assign bus.out_sum = SUM_W'(res_held.sum);
   assign bus.out_count = CNT_W'(res_held.count);
   assign bus.out_sat = res_held.sat;
`ifdef WINDOW_ACC_MINMAX_EN
   assign bus.out_min = DATA_W'(res_held.lo);
   assign bus.out_max = DATA_W'(res_held.hi);
`endif
endmodule
